// File: rtl/rotfpga_pkg.sv
// Shared types and CRC helpers for the rotating-tile grid configuration loader.
package rotfpga_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StDrain,
    StCheck,
    StDone
  } cfg_state_t;

  localparam logic [7:0] CFG_CRC_POLY = 8'h07;

  // One serial step of CRC-8 (MSB-first, no reflection).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/rotfpga_cfg_loader_crc8.sv
// Serial CRC-8 register with synchronous clear and per-bit enable.
module rotfpga_crc8
  import rotfpga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = crc8_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rotfpga_cfg_loader.sv
// Scan-chain configuration loader: streams words into the grid chain and returns readback.
// Optional CRC trailer check enabled by defining ROTFPGA_CFG_CRC_EN.
module rotfpga_cfg_loader
  import rotfpga_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_en,
  output logic              scan_out,
  input  logic              scan_in,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int unsigned BEATS  = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int unsigned LAST_K = CHAIN_LEN - (BEATS - 1) * DATA_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  cfg_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              last_beat;
  logic [CNT_W-1:0]  k;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign k         = last_beat ? CNT_W'(LAST_K) : CNT_W'(DATA_W);

`ifdef ROTFPGA_CFG_CRC_EN
  logic       crc_clr, crc_en;
  logic [7:0] crc;
  logic [7:0] rx_crc;
  logic       crc_err_q, crc_err_d;

  if (DATA_W >= 8) begin : g_rx_wide
    assign rx_crc = in_data[7:0];
  end else begin : g_rx_narrow
    assign rx_crc = 8'(in_data);
  end

  rotfpga_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (sr_q[0]),
    .crc_o (crc)
  );
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
`ifdef ROTFPGA_CFG_CRC_EN
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_err_d = crc_err_q;
`endif
    // Abort wins over any handshake presented in the same cycle.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoad;
            beat_d  = '0;
`ifdef ROTFPGA_CFG_CRC_EN
            crc_clr   = 1'b1;
            crc_err_d = 1'b0;
`endif
          end
        end
        StLoad: begin
          if (in_valid) begin
            sr_d    = in_data;
            cnt_d   = k;
            state_d = StShift;
          end
        end
        StShift: begin
          sr_d  = (sr_q >> 1) | (DATA_W'(scan_in) << (DATA_W - 1));
          cnt_d = cnt_q - 1'b1;
`ifdef ROTFPGA_CFG_CRC_EN
          crc_en = 1'b1;
`endif
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (!last_beat) begin
              beat_d  = beat_q + 1'b1;
              state_d = StLoad;
            end else begin
`ifdef ROTFPGA_CFG_CRC_EN
              state_d = StCheck;
`else
              state_d = StDone;
`endif
            end
          end
        end
        StCheck: begin
`ifdef ROTFPGA_CFG_CRC_EN
          if (in_valid) begin
            if (rx_crc != crc) begin
              crc_err_d = 1'b1;
            end
            state_d = StDone;
          end
`else
          state_d = StIdle;
`endif
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

`ifdef ROTFPGA_CFG_CRC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= crc_err_d;
    end
  end
`endif

  // Every output decodes registered state only.
  always_comb begin
    busy      = (state_q != StIdle);
    scan_en   = (state_q == StShift);
    scan_out  = scan_en & sr_q[0];
    out_valid = (state_q == StDrain);
    out_data  = out_valid ? (sr_q >> (CNT_W'(DATA_W) - k)) : '0;
`ifdef ROTFPGA_CFG_CRC_EN
    in_ready  = (state_q == StLoad) || (state_q == StCheck);
    done      = (state_q == StDone) && !crc_err_q;
    crc_err   = crc_err_q;
`else
    in_ready  = (state_q == StLoad);
    done      = (state_q == StDone);
    crc_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rotfpga_cfg_loader.sv
// Scoreboard bench for rotfpga_cfg_loader with a 20-flop grid chain model.
module tb_rotfpga_cfg_loader;

  localparam int CL = 20;
  localparam int DW = 8;
`ifdef ROTFPGA_CFG_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          scan_en;
  logic          scan_out;
  logic          scan_in;
  logic          busy;
  logic          done;
  logic          crc_err;

  rotfpga_cfg_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .scan_en   (scan_en),
    .scan_out  (scan_out),
    .scan_in   (scan_in),
    .busy      (busy),
    .done      (done),
    .crc_err   (crc_err)
  );

  always #5 clk = ~clk;

  // Grid chain model: scan_out enters at the top, the tail bit0 returns first.
  logic [CL-1:0] chain = '0;
  logic          preload_en = 1'b0;
  logic [CL-1:0] preload_val = '0;
  int            nshift = 0;
  assign scan_in = chain[0];

  always @(posedge clk) begin
    if (preload_en) begin
      chain <= preload_val;
    end else if (scan_en) begin
      chain  <= {scan_out, chain[CL-1:1]};
      nshift <= nshift + 1;
    end
  end

  int            tests = 0;
  int            fails = 0;
  int            done_cnt = 0;
  int            busy_cycles = 0;
  int            ready_mode = 0;
  logic [DW-1:0] sb[$];
  logic [CL-1:0] chain_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_crc(input logic [CL-1:0] bits);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < CL; i++) begin
      if (c[7] ^ bits[i]) c = (c << 1) ^ 8'h07;
      else c = c << 1;
    end
    return c;
  endfunction

  task automatic send_word(input logic [DW-1:0] w);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    step();
    preload_en  = 1'b0;
    chain_exp   = v;
  endtask

  // Full load; the model predicts readbacks from the prior chain image.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int hold0, input bit start_in_load, input bit bad_crc);
    logic [CL-1:0] cfg;
    logic [DW-1:0] cap;
    int            d0;
    int            n;
    cfg = {w2[3:0], w1, w0};
    sb.push_back(chain_exp[7:0]);
    sb.push_back(chain_exp[15:8]);
    sb.push_back({4'h0, chain_exp[19:16]});
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    send_word(w0);
    if (hold0 > 0) begin
      ready_mode = 2;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 100);
      check("drain_reached", 32'(out_valid), 32'd1);
      cap = out_data;
      for (int i = 0; i < hold0; i++) begin
        if (i > 0) @(negedge clk);
        check("hold_scan_en", 32'(scan_en), 32'd0);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_out_data", 32'(out_data), 32'(cap));
      end
      @(posedge clk);
      #1;
      ready_mode = 0;
    end
    send_word(w1);
    if (start_in_load) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!in_ready && n < 100);
      @(posedge clk);
      #1;
      start = 1'b1;
      step();
      step();
      start = 1'b0;
    end
    send_word(w2);
`ifdef ROTFPGA_CFG_CRC_EN
    send_word({{(DW-8){1'b0}}, ref_crc(cfg) ^ {7'd0, bad_crc}});
`endif
    wait_idle();
    step();
    check("chain_image", 32'(chain), 32'(cfg));
    check("done_pulses", done_cnt - d0, bad_crc ? 0 : 1);
    check("crc_err", 32'(crc_err), 32'(bad_crc));
    chain_exp = cfg;
  endtask

  initial begin
    logic [7:0]    w0, w1;
    logic [CL-1:0] p;
    int            s0, d0, b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_readback", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            check("readback", 32'(out_data), 32'(sb.pop_front()));
          end
        end
        if (done) done_cnt++;
        if (busy) busy_cycles++;
      end
      forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
      end
    join_none

    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crc_err", 32'(crc_err), 32'd0);
    rst_n = 1'b1;
    do_preload(20'hABCDE);

    // Directed load with measured busy duration.
    b0 = busy_cycles;
    run_load(8'h11, 8'h22, 8'h03, 0, 1'b0, 1'b0);
    check("busy_cycles", busy_cycles - b0, 27 + int'(CRC_ON));

    // DRAIN stall plus a start pulse while in LOAD.
    run_load(8'h5A, 8'hC3, 8'h0F, 5, 1'b1, 1'b0);

    // Corrupted trailer when the CRC option is present.
    run_load(8'h96, 8'h3C, 8'h07, 0, 1'b0, CRC_ON);

    // Abort on the third SHIFT cycle of beat 1.
    p  = chain_exp;
    w0 = 8'hE7;
    w1 = 8'h4D;
    sb.push_back(p[7:0]);
    s0 = nshift;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(w0);
    send_word(w1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_scan_en", 32'(scan_en), 32'd0);
    check("abort_shifts", nshift - s0, 11);
    chain_exp = (p >> 11) | (20'({w1[2:0], w0}) << 9);
    check("abort_chain", 32'(chain), 32'(chain_exp));
    repeat (4) step();
    check("abort_no_done", done_cnt - d0, 0);

    // Asynchronous reset during SHIFT of beat 0.
    p  = chain_exp;
    w0 = 8'h6B;
    s0 = nshift;
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(w0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_scan_en", 32'(scan_en), 32'd0);
    check("arst_scan_out", 32'(scan_out), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_shifts", nshift - s0, 3);
    chain_exp = (p >> 3) | (20'(w0[2:0]) << 17);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_load(8'hA5, 8'h18, 8'h09, 0, 1'b0, 1'b0);

    // Randomised loads with random readback back-pressure.
    for (int r = 0; r < 6; r++) begin
      if (r == 3) do_preload(20'($urandom));
      ready_mode = 1;
      run_load(8'($urandom), 8'($urandom), 8'($urandom), 0, r == 2, 1'b0);
      ready_mode = 0;
    end

    repeat (3) step();
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rotfpga_cfg_loader.md
# rotfpga_cfg_loader

Parametrised configuration scan controller for the rotating-tile logic grid. It accepts configuration words over a valid/ready stream and serialises them into the grid's scan chain while asserting scan enable. The bits shifted out of the chain's far end are returned as readback words. It replaces direct pin-driven scan control: the top level connects its word stream to the dedicated I/Os and its scan pins to the grid.

## Interface
Parameters:
- `CHAIN_LEN`, 64: total scan-chain length in bits (≥1).
- `DATA_W`, 8: bits per configuration/readback word (1..16).
- `BEATS` (localparam): ceil(CHAIN_LEN/DATA_W).
- `LAST_K` (localparam): CHAIN_LEN − (BEATS−1)·DATA_W, the bit count of the final beat.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load sequence; ignored unless idle.
- `abort` in 1: synchronous cancel of the sequence.
- `in_data` in DATA_W: config word, LSB shifted first.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: word accepted when `in_valid` and `in_ready` are both high.
- `out_data` out DATA_W: readback word, right-aligned, bit0 = first bit returned.
- `out_valid` out 1: readback word available.
- `out_ready` in 1: readback word consumed.
- `scan_en` out 1: grid scan enable.
- `scan_out` out 1: serial data to the grid chain input.
- `scan_in` in 1: serial data from the grid chain end.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `crc_err` out 1: sticky until the next `start`.

## Operation
- States: IDLE → LOAD → SHIFT → DRAIN → (LOAD | CHECK | DONE) → IDLE.
- IDLE:
  - All outputs are 0.
  - `start` moves to LOAD, clears the beat counter and `crc_err`, and presets the CRC to 0x00.
- LOAD:
  - `in_ready` = 1.
  - On handshake, `in_data` is latched into shift register `sr` and k is set: DATA_W for beats 0..BEATS−2, LAST_K for the last beat. Next state is SHIFT.
- SHIFT:
  - `scan_en` = 1 and `scan_out` = `sr[0]` for exactly k cycles.
  - Each cycle: `sr <= {scan_in, sr[DATA_W-1:1]}`, the bit counter decrements, and `scan_out` is folded into the CRC.
  - After k cycles, next state is DRAIN.
- DRAIN:
  - `scan_en` = 0, `out_valid` = 1, `out_data` = `sr >> (DATA_W−k)`.
  - Holds until `out_ready`. Then:
    - not the last beat → LOAD;
    - last beat with `CFG_CRC_EN` defined → CHECK;
    - last beat without `CFG_CRC_EN` → DONE.
- CHECK (only with `CFG_CRC_EN`):
  - `in_ready` = 1.
  - On handshake, `in_data[7:0]` is compared to the running CRC. Mismatch sets `crc_err`. Next state is DONE.
- DONE: `done` = 1 for one cycle only when `crc_err` = 0; next state is IDLE.
- CRC: CRC-8, polynomial x^8+x^2+x+1 (0x07), no reflection, init 0x00, computed over the CHAIN_LEN bits in shift order.
- `abort` in any non-IDLE state:
  - Next cycle is IDLE with `scan_en` low and no `done`.
  - `abort` has priority over all handshakes in the same cycle.
- `start` while busy: ignored.
- Reset mid-operation: immediate IDLE with all outputs 0.
  - The grid chain is left partially shifted. The controller does not repair it; the next sequence reloads the full chain.

## Timing
- Reset value of every output is 0.
- `scan_en`, `in_ready`, `out_valid`, `busy`, `done` and `crc_err` are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Per full beat with immediate handshakes: 1 LOAD cycle + DATA_W SHIFT cycles + 1 DRAIN cycle = DATA_W+2 cycles.
- `scan_in` is sampled on the same edge that advances the chain; it is the grid's registered chain tail.
- Total load time: 1 (start) + Σ(k+2) + [1 CHECK] + 1 DONE cycles.
- A `start` pulse is accepted on the first cycle after reset release.

## Configuration
- Macro `ROTFPGA_CFG_CRC_EN`, when defined:
  - the CHECK state and CRC register exist;
  - the stream carries one extra word after the chain words, holding the expected CRC in bits [7:0];
  - `crc_err` is functional.
- When undefined:
  - no CRC logic and no extra word;
  - DRAIN of the last beat goes directly to DONE;
  - `crc_err` is tied 0.

## Structure
- Shared package `rotfpga_pkg`:
  - state enum `cfg_state_t`;
  - CRC polynomial constant `CFG_CRC_POLY` = 8'h07;
  - function `crc8_step(crc, bit)`.
- Sub-module `rotfpga_crc8` (serial CRC register with clear/enable), instantiated only under the macro.

## Test plan
The bench uses CHAIN_LEN = 20 and DATA_W = 8 (BEATS = 3, LAST_K = 4), with a 20-flop chain model feeding `scan_in`.
- Preload 20'hABCDE; load 8'h11, 8'h22, 8'h03 → readbacks 8'hDE, 8'hBC, 4'hA; the model then holds 20'h32211. `done` pulses once.
- Hold `out_ready` low 5 cycles in DRAIN of beat 0 → `scan_en` stays 0; `in_ready` stays 0; `out_data` remains stable.
- With the macro, send the correct CRC → `done` pulses and `crc_err` = 0. Send CRC xor 1 → `crc_err` = 1 and no `done`.
- Assert `abort` on the 3rd SHIFT cycle of beat 1 → IDLE next cycle; `scan_en` = 0; exactly 11 bits shifted; no `done`.
- Assert `rst_n` low during SHIFT → all outputs 0 asynchronously. `start` after release → full correct load.
- Pulse `start` during LOAD → no effect on beat counter or CRC.
